// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO.
// Register window: +0 TXDATA (write pushes a byte), +4 STATUS (read; clears overflow).
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit, line low
// DATA  | eight data bits, LSB first
// STOP  | stop bit, line high; pops the next byte with no idle gap
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_w_enable,
    input  logic        mem_r_enable,
    output logic [31:0] mem_rdata,
    output logic        txd,
    output logic        tx_busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t          state;
    logic            sel;
    logic            wr_txdata;
    logic            rd_status;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            baud_done;
    logic            overflow;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   count_next;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [7:0]      shift_reg;
    logic [2:0]      bit_idx;
    logic [BW-1:0]   baud_cnt;
    logic [3:0]      count_sat;
    logic [31:0]     status_word;
    logic            unused_bits;

    assign unused_bits = ^{mem_wdata[31:8], mem_addr[1:0]};

    assign sel        = (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign wr_txdata  = sel & mem_w_enable & ~mem_addr[2];
    assign rd_status  = sel & mem_r_enable & mem_addr[2];
    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign baud_done  = (baud_cnt == '0);

    // Acceptance looks only at the pre-edge fill level; a same-cycle pop does not make room.
    assign push = wr_txdata & ~fifo_full & ~reset;
    assign pop  = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_done));

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CW'(1);
        end else if (pop && !push) begin
            count_next = fifo_count - CW'(1);
        end
    end

    always_comb begin
        count_sat = 4'hF;
        if (32'(fifo_count) < 32'd15) begin
            count_sat = 4'(fifo_count);
        end
    end

    assign status_word = {24'b0, count_sat, overflow, tx_busy, fifo_empty, fifo_full};

    // Bus side: registered read data and sticky overflow (a rejected write beats the clear).
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rdata <= '0;
            overflow  <= 1'b0;
        end else begin
            mem_rdata <= rd_status ? status_word : 32'b0;
            if (wr_txdata && fifo_full) begin
                overflow <= 1'b1;
            end else if (rd_status) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            txd       <= 1'b1;
            tx_busy   <= 1'b0;
            shift_reg <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
        end else begin
            // Busy reflects the state and fill level being entered at this edge.
            tx_busy <= (count_next != '0) | pop |
                       ((state != ST_IDLE) & ~((state == ST_STOP) & baud_done));
            case (state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift_reg <= fifo_mem[rd_ptr];
                        baud_cnt  <= BAUD_RELOAD;
                        txd       <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_idx  <= '0;
                        txd      <= shift_reg[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt  <= BAUD_RELOAD;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            txd <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        if (pop) begin
                            shift_reg <= fifo_mem[rd_ptr];
                            baud_cnt  <= BAUD_RELOAD;
                            txd       <= 1'b0;
                            state     <= ST_START;
                        end else begin
                            txd   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: every cycle of txd is compared against a
// frame model built from the bytes each scenario expects to see on the line.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_w_enable = 1'b0;
    logic        mem_r_enable = 1'b0;
    logic [31:0] mem_rdata;
    logic        txd;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [8];
    int         exp_n = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_w_enable(mem_w_enable),
        .mem_r_enable(mem_r_enable),
        .mem_rdata   (mem_rdata),
        .txd         (txd),
        .tx_busy     (tx_busy)
    );

    // Expected line level at negedge c, where c=0 follows the edge of the first write.
    function automatic logic exp_txd(input int c);
        int         f;
        int         b;
        logic [7:0] fb;
        if (c < 1) return 1'b1;
        f = (c - 1) / FRAME;
        b = ((c - 1) % FRAME) / CPB;
        if (f >= exp_n) return 1'b1;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        fb = exp_q[f[2:0]];
        return fb[3'(b - 1)];
    endfunction

    task automatic drive_bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        mem_w_enable = w;
        mem_r_enable = r;
        mem_addr     = a;
        mem_wdata    = d;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [5];
        logic [31:0] exps  [5];
        addrs = '{BASE + 32'd4, BASE, 32'h0000_3004, BASE + 32'd4, 32'h0000_2204};
        exps  = '{32'h02, 32'h00, 32'h00, 32'h02, 32'h00};
        reset = 1'b1;
        drive_bus(1'b1, 1'b1, BASE, 32'h0000_00A5);
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b expected 1", txd); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", tx_busy); end
        checks++;
        if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h expected 0", mem_rdata); end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_bus(1'b0, 1'b1, addrs[i], 32'h0);
            @(negedge clk);
            checks++;
            if (mem_rdata !== exps[i]) begin
                errors++;
                $display("FAIL reset_read addr %h got %h expected %h", addrs[i], mem_rdata, exps[i]);
            end
        end
        drive_bus(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (6) @(negedge clk);
        checks++;
        if (txd !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet txd=%b busy=%b expected txd=1 busy=0", txd, tx_busy);
        end
    endtask

    task automatic test_single_frame();
        exp_q[0] = 8'h55;
        exp_n    = 1;
        for (int c = -1; c <= 41; c++) begin
            if (c >= 0) begin
                checks++;
                if (txd !== exp_txd(c)) begin
                    errors++;
                    $display("FAIL single_txd cycle %0d got %b expected %b", c, txd, exp_txd(c));
                end
                if (c == 1 || c == 40 || c == 41) begin
                    checks++;
                    if (tx_busy !== (c != 41)) begin
                        errors++;
                        $display("FAIL single_busy cycle %0d got %b expected %b", c, tx_busy, (c != 41));
                    end
                end
            end
            if (c == -1) drive_bus(1'b1, 1'b0, BASE, 32'h0000_0155);
            else         drive_bus(1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_q[0] = 8'hA0;
        exp_q[1] = 8'h0F;
        exp_n    = 2;
        for (int c = -1; c <= 81; c++) begin
            if (c >= 0) begin
                checks++;
                if (txd !== exp_txd(c)) begin
                    errors++;
                    $display("FAIL b2b_txd cycle %0d got %b expected %b", c, txd, exp_txd(c));
                end
                if (c == 41 || c == 81) begin
                    checks++;
                    if (tx_busy !== (c == 41)) begin
                        errors++;
                        $display("FAIL b2b_busy cycle %0d got %b expected %b", c, tx_busy, (c == 41));
                    end
                end
            end
            if (c == -1)     drive_bus(1'b1, 1'b0, BASE, 32'h0000_00A0);
            else if (c == 0) drive_bus(1'b1, 1'b0, BASE, 32'h0000_000F);
            else             drive_bus(1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_fifo_fill();
        logic [7:0] bytes [6];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 5; i++) exp_q[i] = bytes[i];
        exp_n = 5;
        for (int c = -1; c <= 201; c++) begin
            if (c >= 0) begin
                checks++;
                if (txd !== exp_txd(c)) begin
                    errors++;
                    $display("FAIL fill_txd cycle %0d got %b expected %b", c, txd, exp_txd(c));
                end
                if (c == 6) begin
                    checks++;
                    if (mem_rdata !== 32'h4D) begin errors++; $display("FAIL fill_status1 got %h expected 4d", mem_rdata); end
                end
                if (c == 7) begin
                    checks++;
                    if (mem_rdata !== 32'h45) begin errors++; $display("FAIL fill_status2 got %h expected 45", mem_rdata); end
                end
                if (c == 201) begin
                    checks++;
                    if (tx_busy !== 1'b0) begin errors++; $display("FAIL fill_busy_end got %b expected 0", tx_busy); end
                end
            end
            if (c <= 4)                drive_bus(1'b1, 1'b0, BASE, {24'h0, bytes[c + 1]});
            else if (c == 5 || c == 6) drive_bus(1'b0, 1'b1, BASE + 32'd4, 32'h0);
            else                       drive_bus(1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_full_pop_overflow();
        logic [7:0] bytes [5];
        bytes = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7};
        for (int i = 0; i < 5; i++) exp_q[i] = bytes[i];
        exp_n = 5;
        for (int c = -1; c <= 201; c++) begin
            if (c >= 0) begin
                checks++;
                if (txd !== exp_txd(c)) begin
                    errors++;
                    $display("FAIL ovf_txd cycle %0d got %b expected %b", c, txd, exp_txd(c));
                end
                if (c == 40) begin
                    checks++;
                    if (mem_rdata !== 32'h45) begin errors++; $display("FAIL ovf_status_full got %h expected 45", mem_rdata); end
                end
                if (c == 42) begin
                    checks++;
                    if (mem_rdata !== 32'h3C) begin errors++; $display("FAIL ovf_status_set got %h expected 3c", mem_rdata); end
                end
                if (c == 43) begin
                    checks++;
                    if (mem_rdata !== 32'h34) begin errors++; $display("FAIL ovf_status_clr got %h expected 34", mem_rdata); end
                end
                if (c == 201) begin
                    checks++;
                    if (tx_busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_end got %b expected 0", tx_busy); end
                end
            end
            if (c <= 3)                          drive_bus(1'b1, 1'b0, BASE, {24'h0, bytes[c + 1]});
            else if (c == 40)                    drive_bus(1'b1, 1'b0, BASE, 32'h0000_003C);
            else if (c == 39 || c == 41 || c == 42) drive_bus(1'b0, 1'b1, BASE + 32'd4, 32'h0);
            else                                 drive_bus(1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_q[0] = 8'h00;
        exp_n    = 1;
        for (int c = -1; c <= 100; c++) begin
            if (c >= 0) begin
                checks++;
                if (c <= 18) begin
                    if (txd !== exp_txd(c)) begin
                        errors++;
                        $display("FAIL midrst_txd cycle %0d got %b expected %b", c, txd, exp_txd(c));
                    end
                end else if (txd !== 1'b1 || tx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_quiet cycle %0d txd=%b busy=%b expected txd=1 busy=0", c, txd, tx_busy);
                end
                if (c == 19) begin
                    checks++;
                    if (mem_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got %h expected 0", mem_rdata); end
                end
                if (c == 20) begin
                    checks++;
                    if (mem_rdata !== 32'h02) begin errors++; $display("FAIL midrst_status got %h expected 02", mem_rdata); end
                end
            end
            reset = (c == 18);
            if (c == -1)      drive_bus(1'b1, 1'b0, BASE, 32'h0000_0000);
            else if (c == 0)  drive_bus(1'b1, 1'b0, BASE, 32'h0000_00FF);
            else if (c == 1)  drive_bus(1'b1, 1'b0, BASE, 32'h0000_00AA);
            else if (c == 18) drive_bus(1'b1, 1'b0, BASE, 32'h0000_0077);
            else if (c == 19) drive_bus(1'b0, 1'b1, BASE + 32'd4, 32'h0);
            else              drive_bus(1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_fill();
        test_full_pop_overflow();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
